regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
Parametrised successor to the processor's 2-read/1-write register file, sitting between the processor and its operand/writeback paths in the skeleton top level. Adds the following:
- N read ports.
- Configurable data and address width.
- Optional write-through bypass.
- A per-register pending scoreboard, so multicycle units (mult/div, dmem loads) can mark a destination busy and the processor can stall on read-after-write hazards.

Parameters:
DATA_WIDTH, 32, width of each register.
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH.
NUM_READ, 2, number of independent combinational read ports (1..4).
BYPASS, 1, 1 = a read of the register being written this cycle returns data_writeReg; 0 = returns the stored value.

Ports:
clock  input  1  master clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high; clears all registers and pending bits.
ctrl_writeEnable  input  1  write data_writeReg into ctrl_writeReg at next rising edge.
ctrl_writeReg  input  ADDR_WIDTH  write index.
data_writeReg  input  DATA_WIDTH  write data.
ctrl_setPending  input  1  mark ctrl_pendingReg busy at next rising edge.
ctrl_pendingReg  input  ADDR_WIDTH  index to mark busy.
ctrl_readReg  input  NUM_READ*ADDR_WIDTH  packed read indices; port i = bits [i*ADDR_WIDTH +: ADDR_WIDTH].
data_readReg  output  NUM_READ*DATA_WIDTH  packed read data; port i = bits [i*DATA_WIDTH +: DATA_WIDTH].
data_readPending  output  NUM_READ  bit i = 1 when port i's register is pending.
anyPending  output  1  OR of all pending bits.

Behaviour:
Reset:
- Asynchronous assertion clears all registers and all pending bits immediately, without waiting for a clock edge.
- While reset is high: data_readReg = 0, data_readPending = 0, anyPending = 0.
- Writes and setPending are ignored while reset is high.
- Reset asserted mid-operation discards any outstanding pending marks.

Register 0:
- Hardwired zero; writes to it are ignored.
- setPending to it is ignored; its pending bit is always 0.
- Reads of index 0 always return 0 and pending = 0, including under bypass.

Writes:
- On rising edge with ctrl_writeEnable = 1 and ctrl_writeReg != 0: reg[ctrl_writeReg] <= data_writeReg.
- The same write clears pending[ctrl_writeReg].

Pending:
- On rising edge with ctrl_setPending = 1 and ctrl_pendingReg != 0: pending[ctrl_pendingReg] <= 1.
- Set and clear on the same index in the same cycle: set wins, pending stays 1 (a new producer was issued).
- Set and clear on different indices in the same cycle: both take effect.

Reads:
- Purely combinational from ctrl_readReg and current state; latency 0.
- All NUM_READ ports are independent and may alias the same index.

BYPASS = 1, when a read index equals ctrl_writeReg, ctrl_writeEnable = 1 and the index != 0:
- data_readReg returns data_writeReg.
- data_readPending returns 0, unless ctrl_setPending targets the same index this cycle, in which case it returns the stored pending bit.

BYPASS = 0:
- Reads return stored state only; a written value is visible from the cycle after the edge.

Widths:
- No arithmetic on data; values pass through unmodified.
- Indices at or above depth do not occur because width equals ADDR_WIDTH.

anyPending:
- Reflects stored pending bits only, not bypass.

Test Plan:
1. Reset, write r5 = 0xDEADBEEF, next cycle read port0 = 5, port1 = 5 -> both ports return 0xDEADBEEF, pending = 00.
2. Write r0 = 0x12345678 with setPending on r0 -> read r0 returns 0x00000000, pending 0, anyPending 0.
3. BYPASS = 1: same cycle write r7 = 0xA5A5A5A5 and read r7 -> data_readReg = 0xA5A5A5A5 combinationally. Repeat with BYPASS = 0 -> returns the old value 0x00000000 until after the edge.
4. Scoreboard:
   - setPending r3 -> next cycle data_readPending = 1 on ports reading r3, anyPending = 1.
   - Write r3 = 0x42 -> next cycle pending = 0, anyPending = 0, data = 0x42.
5. Simultaneous events:
   - r9 pending, setPending r9 and write r9 = 0x1 in the same cycle -> after edge r9 = 0x1 and pending[9] = 1.
   - Set r4 and write r9 in the same cycle -> pending[4] = 1, pending[9] = 0.
6. Async reset mid-operation:
   - Set r2, r6 pending, write r6 = 0xFF.
   - Assert reset between clock edges -> all outputs 0 before the next edge.
   - Deassert reset -> all registers read 0 and anyPending = 0.
   - NUM_READ = 4 variant: all four ports read distinct registers correctly.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with N combinational read ports, optional write-through
// bypass and a per-register pending scoreboard for read-after-write hazard detection.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int BYPASS     = 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0]          ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0]          data_writeReg,
    input  logic                           ctrl_setPending,
    input  logic [ADDR_WIDTH-1:0]          ctrl_pendingReg,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] ctrl_readReg,
    output logic [NUM_READ*DATA_WIDTH-1:0] data_readReg,
    output logic [NUM_READ-1:0]            data_readPending,
    output logic                           anyPending
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      pending;
    logic [DEPTH-1:0]      set_vec;
    logic [DEPTH-1:0]      clr_vec;
    logic                  wr_en;
    logic                  set_en;
    logic [ADDR_WIDTH-1:0] rd_idx;

    // Register 0 is never a legal target for writes or pending marks.
    assign wr_en  = ctrl_writeEnable && (ctrl_writeReg != '0);
    assign set_en = ctrl_setPending && (ctrl_pendingReg != '0);

    assign set_vec = set_en ? (DEPTH'(1) << ctrl_pendingReg) : '0;
    assign clr_vec = wr_en  ? (DEPTH'(1) << ctrl_writeReg)   : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[ctrl_writeReg] <= data_writeReg;
        end
    end

    // Set is applied after clear so a newly issued producer keeps the register busy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_vec) | set_vec;
        end
    end

    always_comb begin
        data_readReg     = '0;
        data_readPending = '0;
        rd_idx           = '0;
        if (!reset) begin
            for (int p = 0; p < NUM_READ; p++) begin
                rd_idx = ctrl_readReg[p*ADDR_WIDTH +: ADDR_WIDTH];
                if ((BYPASS != 0) && wr_en && (rd_idx == ctrl_writeReg)) begin
                    // In-flight write resolves the hazard unless a new producer claims it now.
                    data_readReg[p*DATA_WIDTH +: DATA_WIDTH] = data_writeReg;
                    data_readPending[p] = (set_en && (ctrl_pendingReg == rd_idx)) ?
                                          pending[rd_idx] : 1'b0;
                end else if (rd_idx != '0) begin
                    data_readReg[p*DATA_WIDTH +: DATA_WIDTH] = regs[rd_idx];
                    data_readPending[p] = pending[rd_idx];
                end
            end
        end
    end

    assign anyPending = (|pending) && !reset;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table, async-reset sequence and
// randomized traffic against an array-based model, on a bypass and a non-bypass instance.
module tb_regfile_scoreboard;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        we    = 1'b0;
    logic [4:0]  wi    = '0;
    logic [31:0] wd    = '0;
    logic        st    = 1'b0;
    logic [4:0]  pi    = '0;
    logic [4:0]  rd [4];
    logic [19:0] rd_bus;

    logic [127:0] bp_data;
    logic [3:0]   bp_pend;
    logic         bp_any;
    logic [63:0]  nb_data;
    logic [1:0]   nb_pend;
    logic         nb_any;

    logic [31:0] m_reg  [32];
    bit          m_pend [32];

    int nvec = 0;
    int nerr = 0;

    always #5 clock = ~clock;

    assign rd_bus = {rd[3], rd[2], rd[1], rd[0]};

    regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(4), .BYPASS(1)) dut (
        .clock(clock), .reset(reset),
        .ctrl_writeEnable(we), .ctrl_writeReg(wi), .data_writeReg(wd),
        .ctrl_setPending(st), .ctrl_pendingReg(pi),
        .ctrl_readReg(rd_bus), .data_readReg(bp_data),
        .data_readPending(bp_pend), .anyPending(bp_any)
    );

    regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .BYPASS(0)) dut_nb (
        .clock(clock), .reset(reset),
        .ctrl_writeEnable(we), .ctrl_writeReg(wi), .data_writeReg(wd),
        .ctrl_setPending(st), .ctrl_pendingReg(pi),
        .ctrl_readReg(rd_bus[9:0]), .data_readReg(nb_data),
        .data_readPending(nb_pend), .anyPending(nb_any)
    );

    typedef struct {
        bit          we;
        logic [4:0]  wi;
        logic [31:0] wd;
        bit          st;
        logic [4:0]  pi;
        logic [4:0]  rd;
        logic [31:0] exp_d;
        bit          exp_p;
        bit          exp_any;
        logic [31:0] exp_nb;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_data(input bit byp, input logic [4:0] idx);
        if (reset || idx == 0) return 32'h0;
        if (byp && we && wi == idx) return wd;
        return m_reg[idx];
    endfunction

    function automatic bit exp_pend(input bit byp, input logic [4:0] idx);
        if (reset || idx == 0) return 1'b0;
        if (byp && we && wi == idx) return (st && pi == idx) ? m_pend[idx] : 1'b0;
        return m_pend[idx];
    endfunction

    function automatic bit exp_any();
        bit a = 1'b0;
        if (reset) return 1'b0;
        for (int i = 0; i < 32; i++) a = a | m_pend[i];
        return a;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    task automatic model_update();
        if (we && wi != 0) begin
            m_reg[wi]  = wd;
            m_pend[wi] = 1'b0;
        end
        if (st && pi != 0) m_pend[pi] = 1'b1;
    endtask

    task automatic check_all();
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("bp_data%0d", p), bp_data[p*32 +: 32], exp_data(1'b1, rd[p]));
            chk($sformatf("bp_pend%0d", p), {31'b0, bp_pend[p]}, {31'b0, exp_pend(1'b1, rd[p])});
        end
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("nb_data%0d", p), nb_data[p*32 +: 32], exp_data(1'b0, rd[p]));
            chk($sformatf("nb_pend%0d", p), {31'b0, nb_pend[p]}, {31'b0, exp_pend(1'b0, rd[p])});
        end
        chk("bp_any", {31'b0, bp_any}, {31'b0, exp_any()});
        chk("nb_any", {31'b0, nb_any}, {31'b0, exp_any()});
    endtask

    task automatic drive(input bit w, input logic [4:0] widx, input logic [31:0] wdat,
                         input bit s, input logic [4:0] pidx,
                         input logic [4:0] r0, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] r3);
        we = w; wi = widx; wd = wdat; st = s; pi = pidx;
        rd[0] = r0; rd[1] = r1; rd[2] = r2; rd[3] = r3;
    endtask

    task automatic edge_update();
        @(posedge clock);
        if (!reset) model_update();
        #1;
    endtask

    vec_t tbl [16];

    initial begin
        model_clear();
        for (int i = 0; i < 4; i++) rd[i] = '0;

        tbl[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 5, 32'hDEADBEEF, 0, 0, 32'h0};
        tbl[1]  = '{0, 0, 32'h0,        0, 0, 5, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF};
        tbl[2]  = '{1, 0, 32'h12345678, 1, 0, 0, 32'h0,        0, 0, 32'h0};
        tbl[3]  = '{0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 0, 32'h0};
        tbl[4]  = '{1, 7, 32'hA5A5A5A5, 0, 0, 7, 32'hA5A5A5A5, 0, 0, 32'h0};
        tbl[5]  = '{0, 0, 32'h0,        0, 0, 7, 32'hA5A5A5A5, 0, 0, 32'hA5A5A5A5};
        tbl[6]  = '{0, 0, 32'h0,        1, 3, 3, 32'h0,        0, 0, 32'h0};
        tbl[7]  = '{0, 0, 32'h0,        0, 0, 3, 32'h0,        1, 1, 32'h0};
        tbl[8]  = '{1, 3, 32'h42,       0, 0, 3, 32'h42,       0, 1, 32'h0};
        tbl[9]  = '{0, 0, 32'h0,        0, 0, 3, 32'h42,       0, 0, 32'h42};
        tbl[10] = '{0, 0, 32'h0,        1, 9, 9, 32'h0,        0, 0, 32'h0};
        tbl[11] = '{1, 9, 32'h1,        1, 9, 9, 32'h1,        1, 1, 32'h0};
        tbl[12] = '{0, 0, 32'h0,        0, 0, 9, 32'h1,        1, 1, 32'h1};
        tbl[13] = '{1, 9, 32'h2,        1, 4, 9, 32'h2,        0, 1, 32'h1};
        tbl[14] = '{0, 0, 32'h0,        0, 0, 9, 32'h2,        0, 1, 32'h2};
        tbl[15] = '{0, 0, 32'h0,        0, 0, 4, 32'h0,        1, 1, 32'h0};

        // Reset state, with a write and pending mark that must be ignored.
        drive(1, 5, 32'hCAFEF00D, 1, 5, 5, 5, 0, 5);
        #2;
        check_all();
        chk("rst_data0", bp_data[31:0], 32'h0);
        chk("rst_any", {31'b0, bp_any}, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 5, 5, 0, 5);
        #2;
        chk("rst_ignored_wr", bp_data[31:0], 32'h0);
        chk("rst_ignored_pend", {31'b0, bp_any}, 32'h0);
        edge_update();

        // Directed table
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].we, tbl[i].wi, tbl[i].wd, tbl[i].st, tbl[i].pi,
                  tbl[i].rd, tbl[i].rd, 0, tbl[i].rd);
            #2;
            chk($sformatf("tbl%0d_data", i), bp_data[31:0], tbl[i].exp_d);
            chk($sformatf("tbl%0d_pend", i), {31'b0, bp_pend[0]}, {31'b0, tbl[i].exp_p});
            chk($sformatf("tbl%0d_any", i), {31'b0, bp_any}, {31'b0, tbl[i].exp_any});
            chk($sformatf("tbl%0d_nb", i), nb_data[31:0], tbl[i].exp_nb);
            check_all();
            edge_update();
        end

        // Four distinct registers on four ports
        drive(1, 10, 32'h1010_1010, 0, 0, 0, 0, 0, 0); edge_update();
        drive(1, 11, 32'h1111_1111, 0, 0, 0, 0, 0, 0); edge_update();
        drive(1, 12, 32'h1212_1212, 0, 0, 0, 0, 0, 0); edge_update();
        drive(1, 13, 32'h1313_1313, 0, 0, 0, 0, 0, 0); edge_update();
        drive(0, 0, 0, 0, 0, 13, 10, 12, 11);
        #2;
        chk("nr4_p0", bp_data[31:0],   32'h1313_1313);
        chk("nr4_p1", bp_data[63:32],  32'h1010_1010);
        chk("nr4_p2", bp_data[95:64],  32'h1212_1212);
        chk("nr4_p3", bp_data[127:96], 32'h1111_1111);
        edge_update();

        // Async reset between edges discards state and pending marks
        drive(0, 0, 0, 1, 2, 0, 0, 0, 0); edge_update();
        drive(0, 0, 0, 1, 6, 0, 0, 0, 0); edge_update();
        drive(1, 6, 32'hFF, 0, 0, 6, 2, 13, 9);
        #2;
        chk("pre_rst_any", {31'b0, bp_any}, 32'h1);
        chk("pre_rst_p1", {31'b0, bp_pend[1]}, 32'h1);
        check_all();
        reset = 1'b1;
        #1;
        model_clear();
        chk("async_data", bp_data[31:0] | bp_data[63:32] | bp_data[95:64] | bp_data[127:96], 32'h0);
        chk("async_pend", {28'b0, bp_pend}, 32'h0);
        chk("async_any", {31'b0, bp_any}, 32'h0);
        check_all();
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int b = 0; b < 32; b += 4) begin
            drive(0, 0, 0, 0, 0, 5'(b), 5'(b + 1), 5'(b + 2), 5'(b + 3));
            #2;
            check_all();
            edge_update();
        end

        // Randomized traffic with collisions biased onto a few low registers
        for (int n = 0; n < 400; n++) begin
            logic [4:0] ix [6];
            for (int k = 0; k < 6; k++)
                ix[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                    : 5'($urandom_range(0, 4));
            drive(1'($urandom_range(0, 1)), ix[0], $urandom, 1'($urandom_range(0, 1)), ix[1],
                  ix[2], ix[3], ix[4], ix[5]);
            if ($urandom_range(0, 3) == 0) rd[0] = wi;
            if ($urandom_range(0, 3) == 0) rd[1] = pi;
            #2;
            check_all();
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                #1;
                model_clear();
                check_all();
                @(posedge clock);
                #1;
                reset = 1'b0;
            end else begin
                edge_update();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
